// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage sequencer.
//   Holds one fetched instruction in the ID register. Drives it to the decoder
//   and reads the decoded fields back. Checks those fields against a register
//   scoreboard. Issues to EX over a valid/ready handshake.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both high. ex_valid never depends on ex_ready.
// ex_ins/ex_pc are stable while ex_valid=0 or ex_ready=0 and the entry is held.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   if_valid/if_ready/if_ins/if_pc   fetch -> ID handshake
//   dec_ins                     ID-register instruction to the decoder
//   dec_opcode/rs1/rs2/rd       decoded fields back from the decoder
//   ex_valid/ex_ready/ex_ins/ex_pc   ID -> EX handshake
//   wb_valid/wb_rd              writeback releasing a scoreboard entry
//   flush                       kill the ID-register contents
//   busy_map                    scoreboard; bit i = write to xi pending
//   stall_cnt                   saturating count of hazard-stall cycles
module id_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_ins,
    input  logic [31:0]      if_pc,
    output logic [31:0]      dec_ins,
    input  logic [6:0]       dec_opcode,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [31:0]      ex_ins,
    output logic [31:0]      ex_pc,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_map,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             occ_q, occ_d;
    logic [31:0]      ins_q, ins_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic        use_rs1, use_rs2;
    logic [31:0] wb_mask, eff;
    logic        hazard, issue, accept;

    // Which source operands the current opcode actually reads.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (dec_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    // A register released by writeback this cycle is already free for the
    // hazard check, so a stalled instruction can issue in the release cycle.
    always_comb begin
        wb_mask = '0;
        if (wb_valid) begin
            wb_mask[wb_rd] = 1'b1;
        end
    end

    assign eff = busy_q & ~wb_mask;

    // The rd term is the WAW check; x0 never hazards.
    assign hazard = occ_q & ((use_rs1 & (dec_rs1 != 5'd0) & eff[dec_rs1]) |
                             (use_rs2 & (dec_rs2 != 5'd0) & eff[dec_rs2]) |
                             ((dec_rd != 5'd0) & eff[dec_rd]));

    assign ex_valid = rst_n & occ_q & ~hazard & ~flush;
    assign issue    = ex_valid & ex_ready;
    assign if_ready = rst_n & ~flush & (~occ_q | issue);
    assign accept   = if_valid & if_ready;

    always_comb begin
        occ_d   = occ_q;
        ins_d   = ins_q;
        pc_d    = pc_q;
        busy_d  = busy_q;
        stall_d = stall_q;

        // Flush wins over accept and issue. Accept and issue together keep
        // the entry occupied with the new instruction.
        if (flush) begin
            occ_d = 1'b0;
        end else if (accept) begin
            occ_d = 1'b1;
            ins_d = if_ins;
            pc_d  = if_pc;
        end else if (issue) begin
            occ_d = 1'b0;
        end

        // Clear first, then set, so a same-register release and claim leaves
        // the bit set. Flush leaves the scoreboard alone.
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue && (dec_rd != 5'd0)) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (hazard && !flush && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= 1'b0;
            ins_q   <= NOP;
            pc_q    <= '0;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            occ_q   <= occ_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign dec_ins   = ins_q;
    assign ex_ins    = ins_q;
    assign ex_pc     = pc_q;
    assign busy_map  = busy_q;
    assign stall_cnt = stall_q;

endmodule
